regfile_wb_ctrl: RTL

//   Write-port controller for the 32x32 register file. It arbitrates the single write port
//   (we/a3/wd3) among NREQ writeback requesters using a valid/ready handshake and round-robin

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/regfile_wb_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller:
// default data/address widths and the controller state encoding.
package regfile_pkg;

  localparam int RF_XLEN = 32;
  localparam int RF_AW   = 5;
  localparam int NREG    = 2 ** RF_AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr, wrapping modulo N. Produces a one-hot grant and
// its binary index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0] cand;
  logic        found;

  // Walk the N candidates starting at ptr and latch the first valid one.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[IW-1:0]]    = 1'b1;
        gnt_idx              = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the register file. Arbitrates NREQ writeback
// requesters round-robin onto the single registered write port. x0 writes are
// accepted but dropped.
// Optional feature macro: RF_CLEAR_EN -- after reset, sweep zeros into
// x1..x(NREG-1) before accepting requests (the regfile has no reset).
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic                 init_done
);

  localparam int PW = $clog2(NREQ);

`ifdef RF_CLEAR_EN
  localparam rf_state_t RESET_ST = ST_CLEAR;
  localparam logic [AW-1:0] LAST_ADDR = AW'((2 ** AW) - 1);
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`else
  localparam rf_state_t RESET_ST = ST_RUN;
`endif

  rf_state_t         state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [AW-1:0]     rf_a3_q, rf_a3_d;
  logic [XLEN-1:0]   rf_wd3_q, rf_wd3_d;

  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gnt_idx;
  logic              xfer;
  logic [AW-1:0]     sel_addr;
  logic [XLEN-1:0]   sel_data;

  // Requests are only eligible in RUN and out of reset.
  assign init_done = (state_q == ST_RUN) && rst_n;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid & {NREQ{init_done}}),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_data  = req_data[gnt_idx*XLEN +: XLEN];

  // Next-state: clear sweep, accepted writes, round-robin pointer advance.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rf_we_d  = 1'b0;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
`ifdef RF_CLEAR_EN
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      rf_we_d  = 1'b1;
      rf_a3_d  = clr_cnt_q;
      rf_wd3_d = '0;
      if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
      else                        clr_cnt_d = clr_cnt_q + 1'b1;
    end
`endif
    if (xfer) begin
      // x0 is hardwired zero: the handshake completes but nothing is written.
      rf_we_d  = (sel_addr != '0);
      rf_a3_d  = sel_addr;
      rf_wd3_d = sel_data;
      rr_ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State, pointer and write-port registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RESET_ST;
      rr_ptr_q <= '0;
      rf_we_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd3_q <= '0;
`ifdef RF_CLEAR_EN
      clr_cnt_q <= AW'(1);
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rf_we_q  <= rf_we_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd3_q <= rf_wd3_d;
`ifdef RF_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_a3  = rf_a3_q;
  assign rf_wd3 = rf_wd3_q;

endmodule
